// File: rtl/display_pkg.sv
// Shared grid geometry and wrap-around coordinate helpers for the cursor/display path.
package display_pkg;

  localparam int GRID_W  = 64;
  localparam int GRID_H  = 48;
  localparam int COORD_W = 6;
  localparam int COLOR_W = 3;

  // The limit is compared explicitly because 6-bit overflow only wraps correctly at 64.
  function automatic logic [COORD_W-1:0] wrap_inc(input logic [COORD_W-1:0] coord, input int limit);
    if (int'(coord) >= limit - 1) return '0;
    return coord + COORD_W'(1);
  endfunction

  function automatic logic [COORD_W-1:0] wrap_dec(input logic [COORD_W-1:0] coord, input int limit);
    if (coord == '0) return COORD_W'(limit - 1);
    return coord - COORD_W'(1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-flop sync -> debounced level -> single-cycle step pulse with optional hold-to-repeat.
module button_conditioner
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clock50MHz,
  input  logic reset,
  input  logic raw,
  output logic state,
  output logic pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

  logic            r_sync0;
  logic            r_sync1;
  logic            r_state;
  logic            r_pulse;
  logic            r_first;
  logic [DB_W-1:0] r_db_cnt;
  logic [RP_W-1:0] r_rep_cnt;
  logic            w_flip;
  logic [RP_W-1:0] w_rep_limit;

  assign w_flip      = (r_sync1 != r_state) && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign w_rep_limit = r_first ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_PERIOD - 1);

  always_ff @(posedge clock50MHz or posedge reset) begin
    if (reset) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_state   <= 1'b0;
      r_pulse   <= 1'b0;
      r_first   <= 1'b0;
      r_db_cnt  <= '0;
      r_rep_cnt <= '0;
    end else begin
      r_sync0 <= raw;
      r_sync1 <= r_sync0;

      if ((r_sync1 == r_state) || w_flip) r_db_cnt <= '0;
      else                                r_db_cnt <= r_db_cnt + DB_W'(1);

      if (w_flip) r_state <= ~r_state;

      // Pulse is registered alongside the state flip so both appear in the same cycle.
      r_pulse <= 1'b0;
      if (w_flip) begin
        r_rep_cnt <= '0;
        r_first   <= ~r_state;
        r_pulse   <= ~r_state;
      end else if (r_state && REPEAT_EN) begin
        if (r_rep_cnt == w_rep_limit) begin
          r_pulse   <= 1'b1;
          r_rep_cnt <= '0;
          r_first   <= 1'b0;
        end else begin
          r_rep_cnt <= r_rep_cnt + RP_W'(1);
        end
      end
    end
  end

  assign state = r_state;
  assign pulse = r_pulse;

endmodule

// File: rtl/cursor_input_controller.sv
// Turns board buttons and colour switches into a wrapping cursor position and one-cycle paint writes.
module cursor_input_controller
  import display_pkg::*;
#(
  parameter int GRID_W          = display_pkg::GRID_W,
  parameter int GRID_H          = display_pkg::GRID_H,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clock50MHz,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_paint,
  input  logic [8:0] sw_color,
  output logic [5:0] x_cursor,
  output logic [5:0] y_cursor,
  output logic       write,
  output logic [2:0] r_write,
  output logic [2:0] g_write,
  output logic [2:0] b_write
);

  logic [3:0]           w_dir_raw;
  logic [3:0]           w_dir_pulse;
  logic [3:0]           w_unused_dir_state;
  logic                 w_paint_pulse;
  logic                 w_paint_state;
  logic                 w_move;
  logic                 w_paint_now;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic                 r_write_p0;
  logic                 r_pend_p0;
  logic [3*COLOR_W-1:0] r_color;
  logic [3*COLOR_W-1:0] r_pend_color;

  // Bit order: 0=up, 1=down, 2=left, 3=right.
  assign w_dir_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar gi = 0; gi < 4; gi++) begin : g_dir
    button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (1'b1)
    ) u_btn (
      .clock50MHz(clock50MHz),
      .reset     (reset),
      .raw       (w_dir_raw[gi]),
      .state     (w_unused_dir_state[gi]),
      .pulse     (w_dir_pulse[gi])
    );
  end

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (1'b0)
  ) u_paint (
    .clock50MHz(clock50MHz),
    .reset     (reset),
    .raw       (btn_paint),
    .state     (w_paint_state),
    .pulse     (w_paint_pulse)
  );

  assign w_move      = |w_dir_pulse;
  assign w_paint_now = w_paint_pulse && !w_move;

  // A paint coinciding with a move is deferred one cycle so it lands on the new cell.
  always_ff @(posedge clock50MHz or posedge reset) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_write_p0   <= 1'b0;
      r_pend_p0    <= 1'b0;
      r_color      <= '0;
      r_pend_color <= '0;
    end else begin
      if (w_dir_pulse[0] != w_dir_pulse[1])
        r_y <= w_dir_pulse[0] ? wrap_dec(r_y, GRID_H) : wrap_inc(r_y, GRID_H);
      if (w_dir_pulse[2] != w_dir_pulse[3])
        r_x <= w_dir_pulse[2] ? wrap_dec(r_x, GRID_W) : wrap_inc(r_x, GRID_W);

      r_write_p0 <= w_paint_now || r_pend_p0;
      r_pend_p0  <= (w_paint_pulse || w_paint_state) && w_move;
      if ((w_paint_pulse || w_paint_state) && w_move) r_pend_color <= sw_color;

      if (w_paint_now)    r_color <= sw_color;
      else if (r_pend_p0) r_color <= r_pend_color;
    end
  end

  assign x_cursor = r_x;
  assign y_cursor = r_y;
  assign write    = r_write_p0;
  assign r_write  = r_color[8:6];
  assign g_write  = r_color[5:3];
  assign b_write  = r_color[2:0];

endmodule
